imm_rotate_encoder: RTL and testbench

// Inverse of the datapath operand-2 immediate decoder: takes a 32-bit constant and searches
// for the ARM rotated-immediate form value = imm8 ROR (2*rot4). Multi-cycle, one rotation

---
 rtl/imm_rotate_encoder_if.sv | 29 ++
 rtl/imm_rotate_encoder.sv | 103 ++++++++++
 tb/tb_imm_rotate_encoder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/imm_rotate_encoder_if.sv
// Request/result bundle for the rotated-immediate encoder.
// Latency: none, wires only.
// Backpressure: none; start is only honoured by the encoder while it is idle.
interface imm_rotate_encoder_if #(
   parameter int IMM_W  = 8,
   parameter int ROT_W  = 4,
   parameter int DATA_W = 32
);
   logic                    start;
   logic [DATA_W-1:0]       value;
   logic                    busy;
   logic                    done;
   logic                    valid;
   logic [IMM_W-1:0]        imm8;
   logic [ROT_W-1:0]        rot4;
   logic [ROT_W+IMM_W-1:0]  encoded;

   // Requester side: drives the constant and start, observes the result.
   modport master (
      output start, value,
      input  busy, done, valid, imm8, rot4, encoded
   );

   // Encoder side.
   modport slave (
      input  start, value,
      output busy, done, valid, imm8, rot4, encoded
   );
endinterface

// File: rtl/imm_rotate_encoder.sv
// Finds the smallest rot4 with value == imm8 ROR (2*rot4), one rotation tried per clock.
// Latency: done after edge r+1 for a hit at rotation r, after edge 16 when not encodable.
// Backpressure: start is ignored while busy; done is a one-cycle pulse, a start in that cycle is accepted.
module imm_rotate_encoder #(
   parameter int IMM_W  = 8,
   parameter int ROT_W  = 4,
   parameter int DATA_W = 32
) (
   input logic                 clk,
   input logic                 reset_n,
   imm_rotate_encoder_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, SEARCH = 1'b1} state_t;

   state_t             state, state_nxt;
   logic [ROT_W-1:0]   rcnt, rcnt_nxt;
   logic [DATA_W-1:0]  vreg, vreg_nxt;
   logic               done_q, done_nxt;
   logic               valid_q, valid_nxt;
   logic [IMM_W-1:0]   imm_q, imm_nxt;
   logic [ROT_W-1:0]   rot_q, rot_nxt;

   // Left-rotate by 2*rcnt; a right shift of DATA_W yields zero, covering rcnt == 0.
   logic [ROT_W:0]     lshamt;
   logic [ROT_W+1:0]   rshamt;
   logic [DATA_W-1:0]  cand;
   logic               hit;
   logic               last;

   assign lshamt = {rcnt, 1'b0};
   assign rshamt = (ROT_W + 2)'(DATA_W) - {1'b0, lshamt};
   assign cand   = (vreg << lshamt) | (vreg >> rshamt);
   assign hit    = (cand[DATA_W-1:IMM_W] == '0);
   assign last   = (rcnt == {ROT_W{1'b1}});

   // State and result registers; reset clears everything, including mid-search.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         rcnt    <= '0;
         vreg    <= '0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         imm_q   <= '0;
         rot_q   <= '0;
      end else begin
         state   <= state_nxt;
         rcnt    <= rcnt_nxt;
         vreg    <= vreg_nxt;
         done_q  <= done_nxt;
         valid_q <= valid_nxt;
         imm_q   <= imm_nxt;
         rot_q   <= rot_nxt;
      end
   end

   // Next-state logic: accept in IDLE, test one rotation per cycle in SEARCH.
   // The result fields only change on a done edge, so they survive a new accept.
   always_comb begin
      state_nxt = state;
      rcnt_nxt  = rcnt;
      vreg_nxt  = vreg;
      done_nxt  = 1'b0;
      valid_nxt = valid_q;
      imm_nxt   = imm_q;
      rot_nxt   = rot_q;
      case (state)
         IDLE: begin
            if (bus.start) begin
               vreg_nxt  = bus.value;
               rcnt_nxt  = '0;
               state_nxt = SEARCH;
            end
         end
         SEARCH: begin
            if (hit) begin
               imm_nxt   = cand[IMM_W-1:0];
               rot_nxt   = rcnt;
               valid_nxt = 1'b1;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else if (last) begin
               imm_nxt   = '0;
               rot_nxt   = '0;
               valid_nxt = 1'b0;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else begin
               rcnt_nxt  = rcnt + 1'b1;
            end
         end
      endcase
   end

   assign bus.busy    = (state == SEARCH);
   assign bus.done    = done_q;
   assign bus.valid   = valid_q;
   assign bus.imm8    = imm_q;
   assign bus.rot4    = rot_q;
   assign bus.encoded = {rot_q, imm_q};

endmodule

// File: tb/tb_imm_rotate_encoder.sv
// Bench for imm_rotate_encoder: directed table, handshake/reset sequences, random sweep.
// Latency: measured in edges after the accepting edge.
// Backpressure: start held through a search and re-asserted in the done cycle.
module tb_imm_rotate_encoder;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   imm_rotate_encoder_if bus ();

   imm_rotate_encoder dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] value;
      logic        vld;
      logic [7:0]  imm;
      logic [3:0]  rot;
      int          lat;
   } vec_t;

   vec_t tbl [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
      logic [63:0] d;
      d = {x, x} >> s;
      return d[31:0];
   endfunction

   // True when some imm8 rotated right by 2*r reproduces v.
   function automatic logic fits(input logic [31:0] v, input int r);
      logic [31:0] t;
      t = ror32(v, (32 - 2 * r) % 32);
      return (t[31:8] == 24'h0);
   endfunction

   // Called at a negedge; returns at the negedge where done is seen (or after the bound).
   task automatic run_op(input logic [31:0] v, output int lat, output logic busy_ok);
      bus.start = 1'b1;
      bus.value = v;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      lat = 0;
      busy_ok = 1'b1;
      while (bus.done !== 1'b1 && lat < 40) begin
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (bus.busy !== 1'b0) busy_ok = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic        bok;
      int          dcnt;
      logic [31:0] v;
      logic        smaller;
      logic        any;
      logic        constructed;

      tbl[0]  = '{32'h000000FF, 1'b1, 8'hFF, 4'd0,  1};
      tbl[1]  = '{32'hFF000000, 1'b1, 8'hFF, 4'd4,  5};
      tbl[2]  = '{32'hF000000F, 1'b1, 8'hFF, 4'd2,  3};
      tbl[3]  = '{32'h000003FC, 1'b1, 8'hFF, 4'd15, 16};
      tbl[4]  = '{32'h00000101, 1'b0, 8'h00, 4'd0,  16};
      tbl[5]  = '{32'h00000000, 1'b1, 8'h00, 4'd0,  1};
      tbl[6]  = '{32'h00000104, 1'b1, 8'h41, 4'd15, 16};
      tbl[7]  = '{32'h00AB0000, 1'b1, 8'hAB, 4'd8,  9};
      tbl[8]  = '{32'hFFFFFFFF, 1'b0, 8'h00, 4'd0,  16};
      tbl[9]  = '{32'h000001FE, 1'b0, 8'h00, 4'd0,  16};
      tbl[10] = '{32'h3F000000, 1'b1, 8'h3F, 4'd4,  5};
      tbl[11] = '{32'h00000080, 1'b1, 8'h80, 4'd0,  1};

      bus.start = 1'b0;
      bus.value = 32'h0;
      reset_n   = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_busy",    {31'h0, bus.busy},  32'h0);
      check("reset_done",    {31'h0, bus.done},  32'h0);
      check("reset_valid",   {31'h0, bus.valid}, 32'h0);
      check("reset_imm8",    {24'h0, bus.imm8},  32'h0);
      check("reset_rot4",    {28'h0, bus.rot4},  32'h0);
      check("reset_encoded", {20'h0, bus.encoded}, 32'h0);
      reset_n = 1'b1;
      @(negedge clk);

      // Directed table.
      for (int i = 0; i < 12; i++) begin
         run_op(tbl[i].value, lat, bok);
         check($sformatf("t%0d_latency", i), lat, tbl[i].lat);
         check($sformatf("t%0d_busy", i), {31'h0, bok}, 32'h1);
         check($sformatf("t%0d_valid", i), {31'h0, bus.valid}, {31'h0, tbl[i].vld});
         check($sformatf("t%0d_imm8", i), {24'h0, bus.imm8}, {24'h0, tbl[i].imm});
         check($sformatf("t%0d_rot4", i), {28'h0, bus.rot4}, {28'h0, tbl[i].rot});
         check($sformatf("t%0d_encoded", i), {20'h0, bus.encoded}, {20'h0, tbl[i].rot, tbl[i].imm});
         @(negedge clk);
         check($sformatf("t%0d_done_pulse", i), {31'h0, bus.done}, 32'h0);
      end

      // start held through the search, value changed: only the first value is encoded.
      bus.start = 1'b1;
      bus.value = 32'hFF000000;
      @(posedge clk);
      @(negedge clk);
      bus.value = 32'h000000FF;
      lat = 0;
      while (bus.done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("hold_latency", lat, 5);
      check("hold_rot4", {28'h0, bus.rot4}, 32'h4);
      check("hold_imm8", {24'h0, bus.imm8}, 32'hFF);
      check("hold_busy_at_done", {31'h0, bus.busy}, 32'h0);
      // start still high in the done cycle: accepted at the next edge.
      @(negedge clk);
      check("b2b_busy", {31'h0, bus.busy}, 32'h1);
      check("b2b_rot4_held", {28'h0, bus.rot4}, 32'h4);
      check("b2b_valid_held", {31'h0, bus.valid}, 32'h1);
      bus.start = 1'b0;
      lat = 0;
      while (bus.done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("b2b_latency", lat, 1);
      check("b2b_rot4", {28'h0, bus.rot4}, 32'h0);
      check("b2b_imm8", {24'h0, bus.imm8}, 32'hFF);

      // Asynchronous reset in the middle of a 0x101 search.
      @(negedge clk);
      bus.value = 32'h00000101;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("arst_busy",  {31'h0, bus.busy},  32'h0);
      check("arst_done",  {31'h0, bus.done},  32'h0);
      check("arst_valid", {31'h0, bus.valid}, 32'h0);
      check("arst_imm8",  {24'h0, bus.imm8},  32'h0);
      check("arst_rot4",  {28'h0, bus.rot4},  32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      dcnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.done === 1'b1) dcnt++;
      end
      check("arst_no_done", dcnt, 0);
      check("arst_idle", {31'h0, bus.busy}, 32'h0);

      // Random sweep: alternately raw random words and guaranteed-encodable words.
      for (int k = 0; k < 60; k++) begin
         constructed = k[0];
         if (constructed)
            v = ror32({24'h0, 8'($urandom)}, 2 * int'($urandom_range(0, 15)));
         else
            v = $urandom;
         run_op(v, lat, bok);
         check($sformatf("s%0d_busy", k), {31'h0, bok}, 32'h1);
         if (constructed)
            check($sformatf("s%0d_valid_0x%08h", k, v), {31'h0, bus.valid}, 32'h1);
         if (bus.valid === 1'b1) begin
            smaller = 1'b0;
            for (int r = 0; r < 16; r++)
               if (r < int'(bus.rot4) && fits(v, r)) smaller = 1'b1;
            check($sformatf("s%0d_ror_0x%08h", k, v), ror32({24'h0, bus.imm8}, 2 * int'(bus.rot4)), v);
            check($sformatf("s%0d_minrot_0x%08h", k, v), {31'h0, smaller}, 32'h0);
            check($sformatf("s%0d_latency", k), lat, int'(bus.rot4) + 1);
         end else begin
            any = 1'b0;
            for (int r = 0; r < 16; r++)
               if (fits(v, r)) any = 1'b1;
            check($sformatf("s%0d_unencodable_0x%08h", k, v), {31'h0, any}, 32'h0);
            check($sformatf("s%0d_zero_fields", k), {20'h0, bus.encoded}, 32'h0);
            check($sformatf("s%0d_latency", k), lat, 16);
         end
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
